md_iteration_controller: RTL and testbench
==========================================

Name: md_iteration_controller

Overview:
- Top-level scheduler for a multi-iteration MD run.
- Per iteration, fires the force-evaluation start pulse into the broadcast controller.
- Waits for force evaluation and force write-back to complete, then waits a fixed interconnect drain.
- Launches motion update across all cells and waits for every cell to finish; repeats for a programmed iteration count, then signals completion.

Parameters:
- NUM_CELLS, 64, number of cells / motion-update units.
- ITER_WIDTH, 16, width of iteration count and limit.
- BLANK_CYCLES, 16, cycles after iter_start during which completion flags are ignored (covers broadcast controller 10-cycle start holdoff plus flag deassert latency).
- DRAIN_CYCLES, 8, fixed flush wait between force completion and motion-update start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  run request, sampled only in IDLE
- abort  in  1  synchronous abort, any state
- num_iter  in  ITER_WIDTH  iterations to run, latched on accepted start
- all_reading_done  in  1  all PEs finished reading (from broadcast controller)
- all_force_wr_issued  in  1  all force writes issued and interconnect flushed
- mu_cell_done  in  NUM_CELLS  per-cell motion-update done, level; consumer clears on mu_start
- iter_start  out  1  one-cycle pulse to broadcast controller
- mu_start  out  1  one-cycle pulse to all motion-update units
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion
- iter_count  out  ITER_WIDTH  completed iterations in current or last run
- state_dbg  out  3  state encoding for debug

Behaviour:
- State encoding: IDLE=0, FORCE_START=1, FORCE_EVAL=2, DRAIN=3, MU_START=4, MU_RUN=5, NEXT_ITER=6, DONE=7.
- Outputs are pure decodes of registered state. No combinational input-to-output path.
  - iter_start = (state==FORCE_START)
  - mu_start = (state==MU_START)
  - done = (state==DONE)
  - busy = (state!=IDLE)
- Internal wait counter width = $clog2(max(BLANK_CYCLES,DRAIN_CYCLES,1)+1).
- Reset values: state=IDLE, iter_count=0, num_iter_q=0, wait counter=0. All pulse outputs 0; busy=0.
- IDLE:
  - On start & ~abort: latch num_iter into num_iter_q and clear iter_count.
  - If num_iter==0, go to DONE (zero-iteration run yields a done pulse only); else go to FORCE_START.
- FORCE_START: 1 cycle, then FORCE_EVAL with counter=BLANK_CYCLES.
- FORCE_EVAL:
  - Counter decrements to 0 and holds.
  - When counter==0 & all_reading_done & all_force_wr_issued in the same cycle, go to DRAIN with counter=DRAIN_CYCLES.
  - Flags high while counter!=0 are ignored. This covers stale flags from the previous iteration.
- DRAIN: decrement; when counter==0, go to MU_START.
- MU_START: 1 cycle, then MU_RUN with counter=1 (masks stale mu_cell_done for the mu_start cycle and the next).
- MU_RUN: decrement to 0; when counter==0 & (&mu_cell_done), go to NEXT_ITER.
- NEXT_ITER:
  - iter_count <= iter_count+1.
  - If iter_count+1 == num_iter_q, go to DONE; else go to FORCE_START.
- DONE: 1 cycle, then IDLE. iter_count holds its final value until the next accepted start.
- Minimum cycles per iteration = BLANK_CYCLES+DRAIN_CYCLES+7 (31 with defaults), FORCE_START through NEXT_ITER inclusive.
- abort:
  - In any state other than DONE, abort goes to IDLE next cycle. No done pulse; iter_count retained.
  - In DONE it has no additional effect.
  - abort with start in IDLE: stay IDLE.
- start while busy: ignored; num_iter changes while busy: ignored.
- rst mid-run: all state to reset values next edge, regardless of inputs.
- iter_count never exceeds num_iter_q; no wrap (num_iter max 2^ITER_WIDTH-1 is legal).

Test Plan:
1. Reset, then start with num_iter=1. Flags held high from the start (stale) and mu_cell_done all-ones.
   -> Exactly one iter_start and one mu_start.
   -> done pulses 32 cycles after the start-sampling edge (31 + DONE, defaults); iter_count=1.
2. num_iter=3; flags rise 40 cycles after each iter_start; mu_cell_done bits set one by one over 20 cycles.
   -> 3 iter_start pulses, 3 mu_start pulses; mu_start only after the last bit sets; done once; iter_count=3.
3. num_iter=0 -> done one cycle after start; no iter_start or mu_start; busy high for exactly 1 cycle.
4. all_reading_done high but all_force_wr_issued low for 50 cycles in FORCE_EVAL -> stays in state 2, no mu_start. Raise all_force_wr_issued -> DRAIN entered next edge.
5. Abort during MU_RUN of iteration 2 of 4 -> IDLE next cycle, no done pulse, iter_count=1. start asserted during the run is ignored.
6. rst pulse during DRAIN -> state_dbg=0, iter_count=0, busy=0 next cycle. A new start then runs normally.

Source files
------------

// File: rtl/md_iteration_controller.sv
// Top-level MD run scheduler: per iteration it fires force evaluation, waits for
// force completion plus an interconnect drain, then runs motion update on every cell.
module md_iteration_controller #(
  parameter int NUM_CELLS    = 64,
  parameter int ITER_WIDTH   = 16,
  parameter int BLANK_CYCLES = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] num_iter,
  input  logic                  all_reading_done,
  input  logic                  all_force_wr_issued,
  input  logic [NUM_CELLS-1:0]  mu_cell_done,
  output logic                  iter_start,
  output logic                  mu_start,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [2:0]            state_dbg
);

  localparam int WAIT_MAX = (BLANK_CYCLES > DRAIN_CYCLES)
                          ? ((BLANK_CYCLES > 1) ? BLANK_CYCLES : 1)
                          : ((DRAIN_CYCLES > 1) ? DRAIN_CYCLES : 1);
  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FORCE_START = 3'd1;
  localparam logic [2:0] S_FORCE_EVAL  = 3'd2;
  localparam logic [2:0] S_DRAIN       = 3'd3;
  localparam logic [2:0] S_MU_START    = 3'd4;
  localparam logic [2:0] S_MU_RUN      = 3'd5;
  localparam logic [2:0] S_NEXT_ITER   = 3'd6;
  localparam logic [2:0] S_DONE        = 3'd7;

  logic [2:0]            state;
  logic [CW-1:0]         wait_cnt;
  logic [ITER_WIDTH-1:0] num_iter_q;
  logic [ITER_WIDTH-1:0] iter_next;
  logic                  wait_zero;

  assign iter_next = iter_count + ITER_WIDTH'(1);
  assign wait_zero = (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      num_iter_q <= '0;
      iter_count <= '0;
    end else if (abort && (state != S_DONE)) begin
      // Abort returns to IDLE without a done pulse; iter_count is kept for inspection.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_iter_q <= num_iter;
            iter_count <= '0;
            state      <= (num_iter == '0) ? S_DONE : S_FORCE_START;
          end
        end
        S_FORCE_START: begin
          wait_cnt <= CW'(BLANK_CYCLES);
          state    <= S_FORCE_EVAL;
        end
        S_FORCE_EVAL: begin
          // Completion flags may still be high from the previous iteration until
          // the blanking window has expired.
          if (!wait_zero) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else if (all_reading_done && all_force_wr_issued) begin
            wait_cnt <= CW'(DRAIN_CYCLES);
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wait_zero) state <= S_MU_START;
          else           wait_cnt <= wait_cnt - CW'(1);
        end
        S_MU_START: begin
          wait_cnt <= CW'(1);
          state    <= S_MU_RUN;
        end
        S_MU_RUN: begin
          if (!wait_zero)         wait_cnt <= wait_cnt - CW'(1);
          else if (&mu_cell_done) state <= S_NEXT_ITER;
        end
        S_NEXT_ITER: begin
          iter_count <= iter_next;
          state      <= (iter_next == num_iter_q) ? S_DONE : S_FORCE_START;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign iter_start = (state == S_FORCE_START);
  assign mu_start   = (state == S_MU_START);
  assign done       = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_md_iteration_controller.sv
// Directed bench for md_iteration_controller: table of whole-run vectors plus
// hand-written sequences for blanking, flag gating, abort and reset corner cases.
module tb_md_iteration_controller;

  localparam int NUM_CELLS  = 64;
  localparam int ITER_WIDTH = 16;
  localparam int BOUND      = 2000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic [ITER_WIDTH-1:0] num_iter;
  logic                  all_reading_done;
  logic                  all_force_wr_issued;
  logic [NUM_CELLS-1:0]  mu_cell_done;
  logic                  iter_start;
  logic                  mu_start;
  logic                  busy;
  logic                  done;
  logic [ITER_WIDTH-1:0] iter_count;
  logic [2:0]            state_dbg;

  md_iteration_controller #(
    .NUM_CELLS   (NUM_CELLS),
    .ITER_WIDTH  (ITER_WIDTH),
    .BLANK_CYCLES(16),
    .DRAIN_CYCLES(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .num_iter           (num_iter),
    .all_reading_done   (all_reading_done),
    .all_force_wr_issued(all_force_wr_issued),
    .mu_cell_done       (mu_cell_done),
    .iter_start         (iter_start),
    .mu_start           (mu_start),
    .busy               (busy),
    .done               (done),
    .iter_count         (iter_count),
    .state_dbg          (state_dbg)
  );

  always #5 clk = ~clk;

  int n_is   = 0;
  int n_mu   = 0;
  int n_done = 0;
  always @(negedge clk) begin
    if (iter_start) n_is++;
    if (mu_start)   n_mu++;
    if (done)       n_done++;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency counts edges from the start-sampling edge (inclusive) to the edge
  // that enters DONE, so a 1-iteration run reports 32 = 31 + DONE cycle.
  task automatic run_stale(input int n, output int lat, output int busyc);
    num_iter = ITER_WIDTH'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busyc = busy ? 1 : 0;
    while (!done && lat < BOUND) begin
      tick();
      lat++;
      if (busy) busyc++;
    end
  endtask

  typedef struct {
    int n;
    int exp_lat;
    int exp_pulses;
    int exp_count;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, busyc, is0, mu0, dn0, cyc, viol, fsince, msince, left;
    logic prev_flags, prev_mu_all;
    logic [2:0] prev_state;

    vecs[0] = '{n: 1, exp_lat: 32,  exp_pulses: 1, exp_count: 1};
    vecs[1] = '{n: 0, exp_lat: 1,   exp_pulses: 0, exp_count: 0};
    vecs[2] = '{n: 2, exp_lat: 63,  exp_pulses: 2, exp_count: 2};
    vecs[3] = '{n: 5, exp_lat: 156, exp_pulses: 5, exp_count: 5};

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_iter = '0;
    all_reading_done = 1'b0; all_force_wr_issued = 1'b0; mu_cell_done = '0;
    tick(); tick(); tick();
    check("reset_state", state_dbg, 0);
    check("reset_busy", busy, 0);
    check("reset_iter_count", iter_count, 0);
    check("reset_pulses", {29'd0, iter_start, mu_start, done}, 0);
    rst = 1'b0;
    tick();

    // Stale flags and all-done motion update held high for the whole run.
    all_reading_done = 1'b1; all_force_wr_issued = 1'b1; mu_cell_done = '1;
    foreach (vecs[i]) begin
      is0 = n_is; mu0 = n_mu; dn0 = n_done;
      run_stale(vecs[i].n, lat, busyc);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), busyc, vecs[i].exp_lat);
      tick();
      check($sformatf("v%0d_idle_after", i), {state_dbg, busy}, 0);
      check($sformatf("v%0d_iter_starts", i), n_is - is0, vecs[i].exp_pulses);
      check($sformatf("v%0d_mu_starts", i), n_mu - mu0, vecs[i].exp_pulses);
      check($sformatf("v%0d_done_pulses", i), n_done - dn0, 1);
      check($sformatf("v%0d_iter_count", i), iter_count, vecs[i].exp_count);
      tick();
    end

    // Late force flags and motion-update bits arriving one group per cycle.
    all_reading_done = 1'b0; all_force_wr_issued = 1'b0; mu_cell_done = '0;
    is0 = n_is; mu0 = n_mu; dn0 = n_done;
    num_iter = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    viol = 0; fsince = 1000; msince = 1000;
    prev_flags = 1'b0; prev_mu_all = 1'b0; prev_state = state_dbg;
    fsince = 0;
    cyc = 0;
    while (!done && cyc < BOUND) begin
      tick();
      cyc++;
      if (state_dbg == 3'd3 && prev_state == 3'd2 && !prev_flags) viol++;
      if (state_dbg == 3'd6 && prev_state == 3'd5 && !prev_mu_all) viol++;
      if (iter_start) fsince = 0; else fsince++;
      if (iter_start) begin
        all_reading_done = 1'b0; all_force_wr_issued = 1'b0;
      end else if (fsince >= 40) begin
        all_reading_done = 1'b1; all_force_wr_issued = 1'b1;
      end
      if (mu_start) begin
        msince = 0;
        mu_cell_done = '0;
      end else begin
        msince++;
        for (int b = 0; b < NUM_CELLS; b++)
          if (b < (msince * NUM_CELLS) / 20) mu_cell_done[b] = 1'b1;
      end
      prev_flags  = all_reading_done & all_force_wr_issued;
      prev_mu_all = &mu_cell_done;
      prev_state  = state_dbg;
    end
    check("late_done_seen", done, 1);
    tick();
    check("late_gating_violations", viol, 0);
    check("late_iter_starts", n_is - is0, 3);
    check("late_mu_starts", n_mu - mu0, 3);
    check("late_done_pulses", n_done - dn0, 1);
    check("late_iter_count", iter_count, 3);

    // Only one of the two force flags present: must wait in FORCE_EVAL.
    all_reading_done = 1'b1; all_force_wr_issued = 1'b0; mu_cell_done = '1;
    mu0 = n_mu;
    num_iter = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (state_dbg != 3'd2 && cyc < 20) begin tick(); cyc++; end
    left = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (state_dbg != 3'd2) left++;
    end
    check("partial_flag_stays_eval", left, 0);
    check("partial_flag_no_mu_start", n_mu - mu0, 0);
    all_force_wr_issued = 1'b1;
    tick();
    check("partial_flag_then_drain", state_dbg, 3);
    cyc = 0;
    while (!done && cyc < BOUND) begin tick(); cyc++; end
    check("partial_flag_iter_count", iter_count, 1);
    tick();

    // Abort in MU_RUN of iteration 2 of 4 with start/num_iter wiggled while busy.
    dn0 = n_done; is0 = n_is;
    num_iter = 16'd4; start = 1'b1;
    tick();
    num_iter = 16'd9;
    cyc = 0;
    while (!(state_dbg == 3'd5 && iter_count == 16'd1) && cyc < BOUND) begin tick(); cyc++; end
    check("abort_reached_mu_run", state_dbg, 5);
    abort = 1'b1;
    tick();
    check("abort_to_idle", state_dbg, 0);
    check("abort_busy_low", busy, 0);
    check("abort_iter_count", iter_count, 1);
    tick();
    check("abort_with_start_stays_idle", state_dbg, 0);
    abort = 1'b0; start = 1'b0;
    tick();
    check("abort_no_done", n_done - dn0, 0);
    check("abort_iter_starts", n_is - is0, 2);

    // Synchronous reset during DRAIN of iteration 2, then a clean run.
    num_iter = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(state_dbg == 3'd3 && iter_count == 16'd1) && cyc < BOUND) begin tick(); cyc++; end
    check("rst_reached_drain", state_dbg, 3);
    rst = 1'b1;
    tick();
    check("rst_state", state_dbg, 0);
    check("rst_iter_count", iter_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    run_stale(1, lat, busyc);
    check("post_rst_latency", lat, 32);
    check("post_rst_iter_count", iter_count, 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
